// File: rtl/yarvi_alu_issue.sv
// Issue/operand-staging stage in front of the 64-bit ALU: forwards rs1/rs2, selects and
// conditions operands, and holds them in a main register plus a skid register.
module yarvi_alu_issue #(
    parameter int unsigned XLEN = 64
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            flush,

    input  logic            d_valid,
    output logic            d_ready,
    input  logic [XLEN-1:0] d_pc,
    input  logic            d_insn30,
    input  logic [2:0]      d_funct3,
    input  logic [4:0]      d_rs1,
    input  logic [4:0]      d_rs2,
    input  logic [XLEN-1:0] d_rs1_val,
    input  logic [XLEN-1:0] d_rs2_val,
    input  logic [XLEN-1:0] d_imm,
    input  logic [1:0]      d_op1_sel,
    input  logic            d_op2_imm,
    input  logic            d_word,
    input  logic [4:0]      d_rd,

    input  logic            ex_fwd_valid,
    input  logic [4:0]      ex_fwd_rd,
    input  logic [XLEN-1:0] ex_fwd_val,
    input  logic            wb_fwd_valid,
    input  logic [4:0]      wb_fwd_rd,
    input  logic [XLEN-1:0] wb_fwd_val,

    output logic            ex_valid,
    input  logic            ex_ready,
    output logic            ex_insn30,
    output logic [2:0]      ex_funct3,
    output logic [XLEN-1:0] ex_op1,
    output logic [XLEN-1:0] ex_op2,
    output logic            ex_word,
    output logic [4:0]      ex_rd
);

    typedef struct packed {
        logic            insn30;
        logic [2:0]      funct3;
        logic [XLEN-1:0] op1;
        logic [XLEN-1:0] op2;
        logic            word;
        logic [4:0]      rd;
    } entry_t;

    localparam logic [2:0] F3Sll = 3'b001;
    localparam logic [2:0] F3Sr  = 3'b101;

    // The ex result is newer than the wb result, so it wins when both match.
    function automatic logic [XLEN-1:0] resolve(
        input logic [4:0]      src,
        input logic [XLEN-1:0] rf_val,
        input logic            exv,
        input logic [4:0]      exrd,
        input logic [XLEN-1:0] exval,
        input logic            wbv,
        input logic [4:0]      wbrd,
        input logic [XLEN-1:0] wbval
    );
        if (src == 5'd0)                  return '0;
        else if (exv && (exrd == src))    return exval;
        else if (wbv && (wbrd == src))    return wbval;
        else                              return rf_val;
    endfunction

    logic [XLEN-1:0] rs1_fwd, rs2_fwd, op1_raw, op2_raw;
    logic            is_shift;
    entry_t          stage_e;

    always_comb begin
        rs1_fwd = resolve(d_rs1, d_rs1_val, ex_fwd_valid, ex_fwd_rd, ex_fwd_val,
                          wb_fwd_valid, wb_fwd_rd, wb_fwd_val);
        rs2_fwd = resolve(d_rs2, d_rs2_val, ex_fwd_valid, ex_fwd_rd, ex_fwd_val,
                          wb_fwd_valid, wb_fwd_rd, wb_fwd_val);

        case (d_op1_sel)
            2'b01:   op1_raw = d_pc;
            2'b10:   op1_raw = '0;
            default: op1_raw = rs1_fwd;
        endcase
        op2_raw  = d_op2_imm ? d_imm : rs2_fwd;
        is_shift = (d_funct3 == F3Sll) || (d_funct3 == F3Sr);

        stage_e        = '0;
        stage_e.insn30 = d_insn30;
        stage_e.funct3 = d_funct3;
        stage_e.word   = d_word;
        stage_e.rd     = d_rd;
        stage_e.op1    = op1_raw;
        stage_e.op2    = op2_raw;
        if (is_shift) begin
            stage_e.op2 = d_word ? {{(XLEN-5){1'b0}}, op2_raw[4:0]}
                                 : {{(XLEN-6){1'b0}}, op2_raw[5:0]};
            // Word right shifts see only the low word, extended per SRA/SRL.
            if (d_word && (d_funct3 == F3Sr)) begin
                stage_e.op1 = {{(XLEN-32){d_insn30 & op1_raw[31]}}, op1_raw[31:0]};
            end
        end
    end

    logic   m_valid_q, m_valid_d, s_valid_q, s_valid_d, d_ready_q, d_ready_d;
    entry_t m_q, m_d, s_q, s_d;
    logic   accept, advance;

    assign accept  = d_valid && d_ready_q && !flush;
    assign advance = !m_valid_q || ex_ready;

    always_comb begin
        m_valid_d = m_valid_q;
        s_valid_d = s_valid_q;
        m_d       = m_q;
        s_d       = s_q;
        if (flush) begin
            m_valid_d = 1'b0;
            s_valid_d = 1'b0;
        end else if (advance) begin
            if (s_valid_q) begin
                m_valid_d = 1'b1;
                m_d       = s_q;
                s_valid_d = accept;
                if (accept) s_d = stage_e;
            end else begin
                m_valid_d = accept;
                if (accept) m_d = stage_e;
            end
        end else if (accept) begin
            s_valid_d = 1'b1;
            s_d       = stage_e;
        end
        d_ready_d = !s_valid_d;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            m_valid_q <= 1'b0;
            s_valid_q <= 1'b0;
            d_ready_q <= 1'b1;
            m_q       <= '0;
            s_q       <= '0;
        end else begin
            m_valid_q <= m_valid_d;
            s_valid_q <= s_valid_d;
            d_ready_q <= d_ready_d;
            m_q       <= m_d;
            s_q       <= s_d;
        end
    end

    assign d_ready   = d_ready_q;
    assign ex_valid  = m_valid_q;
    assign ex_insn30 = m_q.insn30;
    assign ex_funct3 = m_q.funct3;
    assign ex_op1    = m_q.op1;
    assign ex_op2    = m_q.op2;
    assign ex_word   = m_q.word;
    assign ex_rd     = m_q.rd;

endmodule
